// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one memory read per accepted request, captures
// the returned word, decodes its fields and faults if memory stays silent too long.
module instr_fetch_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic [25:0] target,
  output logic [31:0] pc_plus4,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        fetch_err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       load_pc, load_instr;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load_pc    = 1'b0;
    load_instr = 1'b0;
    if (flush) begin
      // flush beats any request or memory response arriving in the same cycle
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: if (fetch_req) begin
          state_nxt = S_REQ;
          cnt_nxt   = '0;
          load_pc   = 1'b1;
        end
        S_REQ, S_WAIT: begin
          if (mem_ready) begin
            state_nxt  = S_DONE;
            load_instr = 1'b1;
          end else if (cnt == CNT_LAST) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = cnt + 8'd1;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        S_ERR:   state_nxt = S_ERR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mem_addr <= '0;
      pc_plus4 <= '0;
      instr    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_pc) begin
        mem_addr <= pc_in;
        pc_plus4 <= pc_in + 32'd4;
      end
      if (load_instr) instr <= mem_data;
    end
  end

  assign mem_rd     = (state == S_REQ) || (state == S_WAIT);
  assign fetch_busy = mem_rd;
  assign fetch_done = (state == S_DONE);
  assign fetch_err  = (state == S_ERR);

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: the driver predicts each
// fetch outcome, a negedge monitor checks every completion or fault it observes.
module tb_instr_fetch_unit;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset, fetch_req, flush, mem_ready;
  logic [31:0] pc_in, mem_data;
  logic [31:0] mem_addr, instr, pc_plus4;
  logic        mem_rd, fetch_busy, fetch_done, fetch_err;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  instr_fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .flush(flush),
    .pc_in(pc_in), .mem_ready(mem_ready), .mem_data(mem_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .instr(instr), .op(op), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
    .pc_plus4(pc_plus4), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] addr;
    int          rd_cycles;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_instr = '0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts read-strobe cycles and checks each completion/fault event
  int rd_cnt = 0;
  bit prev_done = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    if (mon_en && reset) begin
      chk("busy_eq_rd", 32'(fetch_busy), 32'(mem_rd));
      if (fetch_done && prev_done) chk("done_one_cycle", 32'(prev_done), 32'd0);
      if ((fetch_done && !prev_done) || (fetch_err && !prev_err)) begin
        if (sbq.size() == 0) begin
          chk("unexpected_event", 32'(fetch_done), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("event_kind_err", 32'(fetch_err), 32'(e.is_err));
          chk("event_kind_done", 32'(fetch_done), 32'(!e.is_err));
          chk("rd_cycles", 32'(rd_cnt), 32'(e.rd_cycles));
          chk("instr", instr, e.instr);
          chk("mem_addr", mem_addr, e.addr);
          chk("pc_plus4", pc_plus4, e.pc4);
          chk("op", 32'(op), e.instr >> 26);
          chk("rs", 32'(rs), (e.instr >> 21) % 32);
          chk("rt", 32'(rt), (e.instr >> 16) % 32);
          chk("rd", 32'(rd), (e.instr >> 11) % 32);
          chk("shamt", 32'(shamt), (e.instr >> 6) % 32);
          chk("funct", 32'(funct), e.instr % 64);
          chk("imm", 32'(imm), e.instr % 65536);
          chk("target", 32'(target), e.instr % 32'h0400_0000);
        end
      end
      rd_cnt    = mem_rd ? rd_cnt + 1 : 0;
      prev_done = fetch_done;
      prev_err  = fetch_err;
    end else begin
      rd_cnt = 0; prev_done = 1'b0; prev_err = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One fetch: `dly` cycles of silence, then a response unless that exceeds the timeout
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int dly, input bit hold);
    exp_t e;
    e.addr = pc;
    e.pc4  = pc + 32'd4;
    if (dly >= TIMEOUT) begin
      e.is_err = 1'b1; e.instr = model_instr; e.rd_cycles = TIMEOUT;
    end else begin
      e.is_err = 1'b0; e.instr = data; e.rd_cycles = dly + 1;
    end
    sbq.push_back(e);
    pc_in = pc; fetch_req = 1'b1;
    tick();
    fetch_req = hold; pc_in = $urandom;
    if (e.is_err) begin
      for (int i = 0; i < TIMEOUT; i++) begin mem_ready = 1'b0; mem_data = $urandom; tick(); end
      mem_ready = 1'b1; mem_data = $urandom; fetch_req = 1'b1;
      tick(); tick();
      chk("err_sticky", 32'(fetch_err), 32'd1);
      chk("err_instr_kept", instr, model_instr);
      flush = 1'b1; mem_ready = 1'b0;
      tick();
      flush = 1'b0; fetch_req = 1'b0;
      chk("flush_clears_err", 32'(fetch_err), 32'd0);
      chk("flush_beats_req", 32'(mem_rd), 32'd0);
    end else begin
      for (int i = 0; i < dly; i++) begin mem_ready = 1'b0; mem_data = $urandom; tick(); end
      mem_ready = 1'b1; mem_data = data;
      tick();
      mem_ready = $urandom_range(0, 1); mem_data = $urandom;
      model_instr = data;
      tick();
      fetch_req = 1'b0; mem_ready = 1'b0;
      chk("idle_after_done", 32'(mem_rd), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; fetch_req = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    pc_in = '0; mem_data = '0;
    tick(); tick();
    chk("rst_instr", instr, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd0);
    chk("rst_flags", {28'd0, mem_rd, fetch_busy, fetch_done, fetch_err}, 32'd0);
    reset = 1'b1; mon_en = 1'b1;
    tick();

    fetch(32'h0000_0040, 32'h012A_4020, 0, 1'b0);
    fetch(32'h0000_1000, 32'h8D09_0004, 5, 1'b0);
    fetch(32'h0000_2000, 32'hDEAD_BEEF, TIMEOUT, 1'b0);
    fetch(32'hFFFF_FFFC, 32'h2108_FFFF, 1, 1'b1);
    fetch(32'h0000_3000, 32'h0C00_1234, TIMEOUT - 1, 1'b1);

    // Abort: flush together with a memory response in WAIT
    pc_in = 32'h0000_5000; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; mem_ready = 1'b0; tick(); tick();
    flush = 1'b1; mem_ready = 1'b1; mem_data = 32'hAAAA_5555; tick();
    flush = 1'b0; mem_ready = 1'b0;
    chk("abort_idle", 32'(mem_rd), 32'd0);
    chk("abort_no_done", 32'(fetch_done), 32'd0);
    chk("abort_instr_kept", instr, model_instr);
    chk("abort_addr_kept", mem_addr, 32'h0000_5000);
    tick();

    // Reset mid-WAIT wins over a simultaneous response
    pc_in = 32'h0000_6000; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; tick(); tick();
    reset = 1'b0; mem_ready = 1'b1; mem_data = 32'h1234_5678; fetch_req = 1'b1; flush = 1'b1; tick();
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_pc4", pc_plus4, 32'd0);
    chk("midrst_flags", {28'd0, mem_rd, fetch_busy, fetch_done, fetch_err}, 32'd0);
    model_instr = '0;
    reset = 1'b1; mem_ready = 1'b0; fetch_req = 1'b0; flush = 1'b0;
    tick();

    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin mem_ready = $urandom_range(0, 1); mem_data = $urandom; tick(); end
      mem_ready = 1'b0;
      fetch($urandom, $urandom, $urandom_range(0, TIMEOUT + 2), 1'($urandom_range(0, 1)));
    end

    tick(); tick();
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum cycles spent waiting for MemReady before the fetch faults (legal range 2..255).
REQ-002 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-003 Reset  input  1  synchronous, active-low reset; sampled on posedge Clk.
REQ-004 FetchReq  input  1  fetch request from the control FSM; honoured only in IDLE.
REQ-005 Flush  input  1  abort any fetch in progress; clears FetchErr.
REQ-006 PCIn  input  32  address of the instruction to fetch; sampled with the accepted FetchReq.
REQ-007 MemReady  input  1  memory read data valid this cycle.
REQ-008 MemData  input  32  memory read data.
REQ-009 MemAddr  output  32  registered read address.
REQ-010 MemRd  output  1  read strobe.
REQ-011 Instr  output  32  instruction register contents.
REQ-012 OP, Funct  output  6 each  Instr[31:26] and Instr[5:0], combinational from Instr.
REQ-013 Rs, Rt, Rd, Shamt  output  5 each  Instr[25:21], [20:16], [15:11], [10:6].
REQ-014 Imm  output  16  Instr[15:0]; Target  output  26  Instr[25:0].
REQ-015 PCPlus4  output  32  captured PCIn + 4.
REQ-016 FetchBusy, FetchDone, FetchErr  output  1 each  status: busy, one-cycle completion pulse, sticky fault.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, REQ, WAIT, DONE, ERR.
REQ-018 In IDLE with FetchReq=1 and Flush=0: MemAddr<=PCIn, PCPlus4<=PCIn+4 (modulo 2^32, carry discarded), wait counter<=0, next state REQ.
REQ-019 In REQ and WAIT, MemRd SHALL be 1 and FetchBusy SHALL be 1; in all other states both SHALL be 0.
REQ-020 In REQ or WAIT with MemReady=1: Instr<=MemData, next state DONE.
REQ-021 In REQ or WAIT with MemReady=0: counter increments; when counter reaches TIMEOUT-1 with MemReady still 0, next state ERR; otherwise next state WAIT.
REQ-022 Minimum latency: FetchReq accepted at cycle n, MemReady=1 at n+1 -> FetchDone=1 and new Instr visible at n+2.
REQ-023 DONE SHALL last exactly one cycle with FetchDone=1, then return to IDLE; a FetchReq in DONE is ignored.
REQ-024 ERR SHALL hold FetchErr=1, leave Instr unchanged, and remain in ERR until Flush=1.
REQ-025 Flush=1 in any state SHALL force next state IDLE, clear FetchErr and the counter, and leave Instr, MemAddr and PCPlus4 unchanged; Flush takes priority over FetchReq and MemReady in the same cycle.
REQ-026 FetchReq in REQ, WAIT, DONE or ERR SHALL be ignored and not queued.
REQ-027 MemReady outside REQ and WAIT SHALL be ignored.
REQ-028 Instr SHALL change only on the REQ/WAIT->DONE transition or on reset.
REQ-029 Decoded field outputs SHALL track Instr with no extra cycle of latency.

Reset
REQ-030 With Reset=0 at a posedge: state IDLE; Instr, MemAddr, PCPlus4 and counter = 0; MemRd, FetchBusy, FetchDone and FetchErr = 0.
REQ-031 Reset SHALL take priority over Flush, FetchReq and MemReady, and SHALL abort a fetch mid-operation with no FetchDone pulse.

Verification
REQ-032 Basic fetch: PCIn=0x00000040, FetchReq pulse, MemReady=1 next cycle with MemData=0x012A4020 -> FetchDone at n+2; OP=0x00, Funct=0x20, Rs=9, Rt=10, Rd=8, PCPlus4=0x00000044.
REQ-033 Wait states: MemReady delayed 5 cycles, MemData=0x8D090004 -> MemRd high for 6 cycles, FetchDone once, OP=0x23, Imm=0x0004.
REQ-034 Timeout: TIMEOUT=16, MemReady held 0 -> ERR entered after 16 cycles in REQ/WAIT; FetchErr stays 1 and Instr is unchanged; Flush -> IDLE with FetchErr=0.
REQ-035 Wrap: PCIn=0xFFFFFFFC -> PCPlus4=0x00000000.
REQ-036 Abort: Flush asserted in WAIT together with MemReady=1 -> IDLE, no FetchDone, Instr unchanged; then Reset=0 mid-WAIT -> all outputs at reset values the next cycle.
REQ-037 Ignored request: FetchReq held high through DONE -> exactly one fetch per IDLE acceptance, no back-to-back DONE.
